// File: rtl/busy_timer_arbiter_pkg.sv
// Shared definitions for the busy-timer arbiter: FSM encoding, default
// counter width and a constant-width helper.
package busy_timer_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CW_DEFAULT = 16;

    // Bits needed to hold an index 0..n-1, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/busy_timer_arbiter_timer.sv
// Loadable countdown: holds the remaining cycles of the current grant.
// The counter saturates at zero so it can never wrap.
module busy_timer
    import busy_timer_arbiter_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_value,
    output logic          o_zero,
    output logic          o_busy
);

    logic [CW-1:0] count;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign o_zero = (count == '0);
    assign o_busy = (count != '0);

endmodule

// File: rtl/busy_timer_arbiter.sv
// Round-robin arbiter sharing one busy-countdown timer among NREQ
// requesters. A winner owns the resource for max(len,1) cycles; the next
// arbitration happens in the last cycle so grants can run back-to-back.
module busy_timer_arbiter
    import busy_timer_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*CW-1:0]     i_len,
    output logic [NREQ-1:0]        o_ack,
    output logic [NREQ-1:0]        o_grant,
    output logic [clog2(NREQ)-1:0] o_owner,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int OW = clog2(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [OW-1:0]   ptr;
    logic [OW:0]     pick;
    logic            arb_point;
    logic            win;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   ptr_nxt;
    logic [CW-1:0]   win_len;
    logic [CW-1:0]   load_value;
    logic            timer_zero;
    logic            timer_busy;

    // First asserted request scanning upward from ptr, wrapping modulo NREQ.
    // Returns {found, index}; the reverse loop lets the nearest one win.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [OW-1:0]   start);
        logic [OW:0] res;
        int          k;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(start) + i) % NREQ;
            if (req[k]) begin
                res = {1'b1, OW'(k)};
            end
        end
        return res;
    endfunction

    busy_timer #(
        .CW(CW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (win),
        .i_value (load_value),
        .o_zero  (timer_zero),
        .o_busy  (timer_busy)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, timer load value and next state.
    always_comb begin
        state_nxt  = IDLE;
        pick       = rr_pick(i_req, ptr);
        arb_point  = (state == IDLE) || timer_zero;
        win        = arb_point && pick[OW];
        win_idx    = pick[OW-1:0];
        ptr_nxt    = (win_idx == OW'(NREQ - 1)) ? '0 : win_idx + OW'(1);
        win_len    = i_len[int'(win_idx)*CW +: CW];
        load_value = (win_len == '0) ? '0 : win_len - CW'(1);
        if (win) begin
            state_nxt = RUN;
        end else if (state == RUN && timer_busy) begin
            state_nxt = RUN;
        end
    end

    // Grant, ack, owner and round-robin pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ack   <= '0;
            o_grant <= '0;
            o_owner <= '0;
            ptr     <= '0;
        end else begin
            o_ack <= '0;
            if (win) begin
                o_ack   <= NREQ'(1) << win_idx;
                o_grant <= NREQ'(1) << win_idx;
                o_owner <= win_idx;
                ptr     <= ptr_nxt;
            end else if (arb_point) begin
                o_grant <= '0;
            end
        end
    end

    assign o_busy = (state == RUN);
    assign o_done = (state == RUN) && timer_zero;

endmodule

// File: tb/tb_busy_timer_arbiter.sv
// Directed bench for busy_timer_arbiter (NREQ=4, CW=16). Expected output
// vectors {ack, grant, owner, busy, done} are queued as stimulus is applied
// and compared one per clock, #1 after the rising edge.
module tb_busy_timer_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 16;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*CW-1:0]  len;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     grant;
    logic [1:0]          owner;
    logic                busy;
    logic                done;

    logic [11:0]         exp_q[$];
    string               tag_q[$];
    int                  errors;
    int                  checks;

    busy_timer_arbiter #(
        .NREQ(NREQ),
        .CW  (CW)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_req   (req),
        .i_len   (len),
        .o_ack   (ack),
        .o_grant (grant),
        .o_owner (owner),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] a, input logic [3:0] g,
                        input logic [1:0] o, input logic b, input logic d);
        exp_q.push_back({a, g, o, b, d});
        tag_q.push_back(tag);
    endtask

    task automatic set_len(input int n, input logic [CW-1:0] v);
        len[n*CW +: CW] = v;
    endtask

    task automatic tick();
        logic [11:0] e;
        logic [11:0] obs;
        string       t;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            obs = {ack, grant, owner, busy, done};
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed ack/grant/owner/busy/done=%h required=%h", t, obs, e);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        req    = '0;
        len    = '0;

        // Reset state.
        push("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        push("idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        // Single request, len 5, from IDLE.
        req = 4'b0100;
        set_len(2, 16'd5);
        push("t1_ack", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            push("t1_hold", 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
            tick();
        end
        push("t1_done", 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        push("t1_idle", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();

        // Pointer is 3: req[3] beats req[0], then req[0] follows.
        req = 4'b1001;
        set_len(0, 16'd1);
        set_len(3, 16'd1);
        push("t4_g3", 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
        tick();
        req = 4'b0001;
        push("t4_g0", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
        tick();
        req = '0;
        push("t4_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        // len 0 acts as len 1: ack and done in the same cycle.
        req = 4'b0010;
        set_len(1, 16'd0);
        push("t3_len0", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        req = '0;
        push("t3_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();

        // Reset in cycle 3 of a len 10 grant; afterwards pointer restarts at 0.
        req = 4'b0110;
        set_len(1, 16'd2);
        set_len(2, 16'd10);
        push("t5_ack", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        push("t5_c2", 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        push("t5_c3", 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        push("t5_abort", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        push("t5_regrant", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        req = '0;
        push("t5_done", 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        push("t5_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();

        // Fresh reset so the rotation starts at requester 0.
        reset = 1'b1;
        push("t2_reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // All four requesting, len 2 each: 0,1,2,3,0 back-to-back.
        req = 4'b1111;
        for (int n = 0; n < NREQ; n++) set_len(n, 16'd2);
        for (int g = 0; g < 5; g++) begin
            push("t2_ack", 4'(1 << (g % 4)), 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
            tick();
            if (g == 4) req = '0;
            push("t2_done", 4'b0000, 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b1);
            tick();
        end
        push("t2_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        // Maximum length: 65535 cycles, counter must not wrap.
        req = 4'b0001;
        set_len(0, 16'hFFFF);
        push("t6_ack", 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        req = '0;
        for (int i = 0; i < 65533; i++) begin
            push("t6_hold", 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
            tick();
        end
        push("t6_done", 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
        tick();
        push("t6_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        push("t6_stay", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
